// File: rtl/memory_writeback_register.sv
// MEM/WB pipeline register with stall, bubble injection and writeback-data select.
// Optional bubble-on-flush behaviour is compiled in by defining MEMWB_FLUSH_EN.
module memory_writeback_register #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  wbs_in,
  input  logic [DATA_WIDTH-1:0] memData_in,
  input  logic [DATA_WIDTH-1:0] ALUresult_in,
  output logic                  wbs_out,
  output logic [DATA_WIDTH-1:0] memData_out,
  output logic [DATA_WIDTH-1:0] ALUresult_out,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  output logic                  valid_out
);

  // Handshake: valid_out=1 marks a real instruction held in the stage; there is
  // no ready, the WB stage consumes whatever is presented every cycle, and the
  // upstream stage stalls this register by dropping en.
  logic flush_active;

`ifdef MEMWB_FLUSH_EN
  assign flush_active = flush;
`else
  // Port kept for a uniform interface; folded to a constant so it never acts.
  assign flush_active = flush & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_out       <= 1'b0;
      memData_out   <= '0;
      ALUresult_out <= '0;
      valid_out     <= 1'b0;
    end else if (flush_active) begin
      wbs_out       <= 1'b0;
      memData_out   <= '0;
      ALUresult_out <= '0;
      valid_out     <= 1'b0;
    end else if (en) begin
      wbs_out       <= wbs_in;
      memData_out   <= memData_in;
      ALUresult_out <= ALUresult_in;
      valid_out     <= 1'b1;
    end
  end

  assign wb_data_out = wbs_out ? memData_out : ALUresult_out;

endmodule

// File: tb/tb_memory_writeback_register.sv
// Scoreboarded bench for memory_writeback_register: directed checks then random traffic.
// Expected flush behaviour follows the MEMWB_FLUSH_EN macro of the build.
module tb_memory_writeback_register;
  localparam int W  = 16;
  localparam int VW = 3 * W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         wbs_in = 1'b0;
  logic [W-1:0] memData_in = '0;
  logic [W-1:0] ALUresult_in = '0;
  logic         wbs_out;
  logic [W-1:0] memData_out;
  logic [W-1:0] ALUresult_out;
  logic [W-1:0] wb_data_out;
  logic         valid_out;

  // expected vector = {valid, wbs, mem, alu, wb_data}
  logic [VW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  bit rst_seen = 1'b0;

  memory_writeback_register #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .wbs_in(wbs_in), .memData_in(memData_in), .ALUresult_in(ALUresult_in),
    .wbs_out(wbs_out), .memData_out(memData_out), .ALUresult_out(ALUresult_out),
    .wb_data_out(wb_data_out), .valid_out(valid_out)
  );

  // clock / reset block (reset is driven through the stimulus table)
  always #5 clk = ~clk;

`ifdef MEMWB_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  // reference model: the stage as one record, updated by the edge rules
  initial begin : ref_model
    bit           m_valid = 1'b0;
    bit           m_wbs   = 1'b0;
    logic [W-1:0] m_mem   = '0;
    logic [W-1:0] m_alu   = '0;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b0) begin
        m_valid = 0; m_wbs = 0; m_mem = '0; m_alu = '0;
        rst_seen = 1'b1;
      end else if (FLUSH_ON && flush === 1'b1) begin
        m_valid = 0; m_wbs = 0; m_mem = '0; m_alu = '0;
      end else if (en === 1'b1) begin
        m_valid = 1; m_wbs = wbs_in; m_mem = memData_in; m_alu = ALUresult_in;
      end
      if (rst_seen)
        exp_q.push_back({m_valid, m_wbs, m_mem, m_alu, (m_wbs ? m_mem : m_alu)});
    end
  end

  function automatic string fmt(input logic [VW-1:0] v);
    return $sformatf("v=%0b wbs=%0b mem=%h alu=%h wb=%h",
                     v[VW-1], v[VW-2], v[3*W-1:2*W], v[2*W-1:W], v[W-1:0]);
  endfunction

  // monitor: after each edge compare with the model, then again mid-cycle
  // after the driver has changed inputs, to prove outputs held between edges
  initial begin : monitor
    logic [VW-1:0] act;
    logic [VW-1:0] last_exp;
    forever begin
      @(posedge clk);
      #1;
      act = {valid_out, wbs_out, memData_out, ALUresult_out, wb_data_out};
      if (exp_q.size() != 0) begin
        last_exp = exp_q.pop_front();
        tests++;
        if (act !== last_exp) begin
          fails++;
          $display("FAIL edge_check t=%0t got %s expected %s", $time, fmt(act), fmt(last_exp));
        end
        @(negedge clk);
        #1;
        act = {valid_out, wbs_out, memData_out, ALUresult_out, wb_data_out};
        tests++;
        if (act !== last_exp) begin
          fails++;
          $display("FAIL hold_check t=%0t got %s expected %s", $time, fmt(act), fmt(last_exp));
        end
      end else if (rst_seen) begin
        tests++;
        fails++;
        $display("FAIL no_expected t=%0t got %s expected queued entry", $time, fmt(act));
      end
    end
  end

  // driver: new inputs right at the falling edge, sampled at the next rising edge
  task automatic step(input bit r, input bit e, input bit f, input bit w,
                      input logic [W-1:0] md, input logic [W-1:0] ar);
    @(negedge clk);
    rst_n = r; en = e; flush = f; wbs_in = w; memData_in = md; ALUresult_in = ar;
  endtask

  initial begin : stimulus
    // pre-reset cycles: outputs undefined, nothing checked
    step(1, 1, 0, 1, 16'h1111, 16'h2222);
    step(1, 0, 0, 0, 16'h3333, 16'h4444);
    // reset with non-zero inputs, then the memory and ALU loads
    step(0, 1, 0, 1, 16'h1234, 16'hABCD);
    step(1, 1, 0, 1, 16'h1234, 16'hABCD);
    step(1, 1, 0, 0, 16'h5678, 16'h9876);
    // stall for two edges with disturbing inputs
    step(1, 0, 0, 1, 16'hFFFF, 16'h0000);
    step(1, 0, 0, 1, 16'hFFFF, 16'h0000);
    // flush while stalled, reload, flush while loading
    step(1, 0, 1, 1, 16'hFFFF, 16'h0000);
    step(1, 1, 0, 1, 16'hFFFF, 16'h0001);
    step(1, 1, 1, 0, 16'h0F0F, 16'hF0F0);
    step(1, 1, 0, 0, 16'h8000, 16'h7FFF);
    // reset overrides flush and en on the same edge
    step(0, 1, 1, 1, 16'hDEAD, 16'hBEEF);
    step(1, 1, 0, 1, 16'hDEAD, 16'hBEEF);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0), ($urandom_range(2) != 0),
           ($urandom_range(5) == 0), $urandom_range(1),
           W'($urandom), W'($urandom));
    end
    step(1, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
